// File: rtl/btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse
//
// Purpose
//   Front-end conditioner for a raw push-button that sits directly upstream of
//   the LED speed driver. The raw pin is synchronised and its polarity is
//   normalised. Contact bounce is rejected on both press and release. Each
//   confirmed press produces exactly one single-cycle pulse. A debounced
//   level, a wrapping press counter and the FSM state are exported for
//   status.
//
// Optional feature
//   BTN_AUTOREPEAT_EN  When defined, holding the button emits repeat pulses.
//                      The first repeat comes REPEAT_START cycles after the
//                      press pulse, then one every REPEAT_PERIOD cycles while
//                      the button stays in the PRESSED state. When undefined,
//                      no hold counter exists and each debounced press gives
//                      exactly one pulse.
//
// Parameters
//   ACTIVE_LOW     1: pin reads 0 when pressed (pull-up); 0: pin reads 1 when pressed
//   CNT_W          width of the debounce and hold counters
//   DEBOUNCE_CYC   stable cycles needed to accept an edge (2 .. 2^CNT_W-1)
//   REPEAT_START   hold cycles before the first auto-repeat pulse
//   REPEAT_PERIOD  cycles between later auto-repeat pulses
//
// Ports
//   CLK        in   1  system clock
//   RESET      in   1  synchronous, active-high reset
//   iBtn       in   1  raw asynchronous button pin
//   oPulse     out  1  one-cycle high per accepted press (plus repeats if enabled)
//   oLevel     out  1  debounced pressed level, 1 = pressed
//   oPressCnt  out  8  number of oPulse assertions, wraps 255 -> 0
//   oState     out  2  current FSM state (0 IDLE, 1 PRESS_WAIT, 2 PRESSED,
//                      3 RELEASE_WAIT), exported for debug and checkers
//
// Handshake
//   There is no valid/ready exchange. oPulse is a registered strobe that is
//   valid for exactly one CLK cycle and is never high on two consecutive
//   cycles. The consumer samples it on any CLK edge and needs no
//   back-pressure.
// -----------------------------------------------------------------------------
module btn_debounce_pulse #(
    parameter int ACTIVE_LOW    = 1,
    parameter int CNT_W         = 25,
    parameter int DEBOUNCE_CYC  = 270000,
    parameter int REPEAT_START  = 13500000,
    parameter int REPEAT_PERIOD = 2700000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       iBtn,
    output logic       oPulse,
    output logic       oLevel,
    output logic [7:0] oPressCnt,
    output logic [1:0] oState
);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    // Raw pin level that means "released". The synchroniser is reset to this
    // level so that a reset never fakes a press.
    localparam logic RAW_RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // The terminal count is compared with ==. The counter starts at 0, so
    // reaching DEBOUNCE_CYC-1 means the input has been stable long enough.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    // ------------------------------------------------------------------
    // Input synchroniser and polarity normalisation
    // ------------------------------------------------------------------
    logic r_sync0;
    logic r_sync1;
    logic w_p;          // 1 = pressed, after synchronisation

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync0 <= RAW_RELEASED;
            r_sync1 <= RAW_RELEASED;
        end else begin
            r_sync0 <= iBtn;
            r_sync1 <= r_sync0;
        end
    end

    assign w_p = (ACTIVE_LOW != 0) ? ~r_sync1 : r_sync1;

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             w_press_accept;   // debounced press confirmed this cycle
    logic             w_rep_fire;       // auto-repeat strobe (0 if feature off)
    logic             r_pulse;
    logic [7:0]       r_press_cnt;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_level_nxt    = r_level;
        w_press_accept = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_p) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end

            S_PRESS_WAIT: begin
                if (!w_p) begin
                    // The press was a bounce: drop it without a pulse.
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt    = S_PRESSED;
                    w_cnt_nxt      = '0;
                    w_level_nxt    = 1'b1;
                    w_press_accept = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_PRESSED: begin
                if (!w_p) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end

            S_RELEASE_WAIT: begin
                if (w_p) begin
                    // Release bounce: go back to PRESSED quietly. The button
                    // never really left, so no new pulse is due.
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat hold counter
    // ------------------------------------------------------------------
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RS_LAST = CNT_W'(REPEAT_START - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             r_repeating;    // first repeat already emitted
    logic             w_repeating_nxt;

    always_comb begin
        w_hold_nxt      = '0;
        w_repeating_nxt = 1'b0;
        w_rep_fire      = 1'b0;

        // The hold counter runs only in PRESSED. In every other state it is
        // held at 0, so it restarts on each entry to PRESSED, whether that
        // entry comes from PRESS_WAIT or from RELEASE_WAIT.
        if (r_state == S_PRESSED) begin
            if (r_hold == (r_repeating ? RP_LAST : RS_LAST)) begin
                w_rep_fire      = 1'b1;
                w_hold_nxt      = '0;
                w_repeating_nxt = 1'b1;
            end else begin
                w_hold_nxt      = r_hold + 1'b1;
                w_repeating_nxt = r_repeating;
            end
            // A repeat that coincides with the release edge still fires.
            // The counter clears because the FSM leaves PRESSED on this edge.
            if (!w_p) begin
                w_hold_nxt      = '0;
                w_repeating_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hold      <= '0;
            r_repeating <= 1'b0;
        end else begin
            r_hold      <= w_hold_nxt;
            r_repeating <= w_repeating_nxt;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pulse     <= 1'b0;
            r_press_cnt <= 8'd0;
        end else begin
            r_pulse <= w_press_accept | w_rep_fire;
            if (w_press_accept | w_rep_fire) begin
                r_press_cnt <= r_press_cnt + 8'd1;   // wraps naturally at 255
            end
        end
    end

    assign oPulse    = r_pulse;
    assign oLevel    = r_level;
    assign oPressCnt = r_press_cnt;
    assign oState    = r_state;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_pulse
//
// Testbench for btn_debounce_pulse. It runs directed scenarios and then a
// randomised button waveform. A behavioural model derives the expected
// outputs from run lengths of the synchronised input: a level change is
// accepted after DEBOUNCE_CYC+1 consecutive samples that differ from it.
// Repeat pulses are placed by hold-time arithmetic. The outputs are compared
// against this model on every cycle, and literal checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_btn_debounce_pulse;

    localparam int DB = 4;
    localparam int RS = 20;
    localparam int RP = 8;
    localparam int CW = 8;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic       iBtn  = 1'b1;
    logic       oPulse;
    logic       oLevel;
    logic [7:0] oPressCnt;
    logic [1:0] oState;

    always #5 CLK = ~CLK;

    btn_debounce_pulse #(
        .ACTIVE_LOW   (1),
        .CNT_W        (CW),
        .DEBOUNCE_CYC (DB),
        .REPEAT_START (RS),
        .REPEAT_PERIOD(RP)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .iBtn     (iBtn),
        .oPulse   (oPulse),
        .oLevel   (oLevel),
        .oPressCnt(oPressCnt),
        .oState   (oState)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    int         cyc = 0;     // number of posedges so far
    bit         chk_en = 1'b0;
    logic       m_s0 = 1'b1;
    logic       m_s1 = 1'b1;
    bit         m_level = 1'b0;
    int         m_run = 0;     // consecutive samples disagreeing with m_level
    int         m_since = 0;   // edges spent settled in the pressed state
    bit         m_pulse = 1'b0;
    logic [7:0] m_cnt = 8'd0;

    always @(posedge CLK) begin
        bit p;
        bit fire;
        bit rise;
        p = (m_s1 == 1'b0);
        cyc++;
        if (RESET) begin
            m_s0 = 1'b1; m_s1 = 1'b1;
            m_level = 1'b0; m_run = 0; m_since = 0;
            m_pulse = 1'b0; m_cnt = 8'd0;
            chk_en = 1'b1;
        end else begin
            m_s1 = m_s0;
            m_s0 = iBtn;
            fire = 1'b0;
            rise = 1'b0;
            if (m_level && m_run == 0) begin
                m_since++;
                fire = AUTOREP && (m_since == RS || (m_since > RS && (m_since - RS) % RP == 0));
                if (!p) m_since = 0;
            end else begin
                m_since = 0;
            end
            if (p != m_level) m_run++;
            else              m_run = 0;
            if (m_run == DB + 1) begin
                m_level = ~m_level;
                m_run   = 0;
                rise    = m_level;
            end
            m_pulse = rise | fire;
            if (m_pulse) m_cnt++;
        end
    end

    // ---------------- per-cycle compare ----------------
    int  pulse_total = 0;
    int  b2b = 0;
    bit  prev_pulse = 1'b0;
    logic [31:0] pulse_q[$];
    logic [31:0] exp_q[$];

    always @(negedge CLK) begin
        logic [1:0] exp_state;
        if (chk_en) begin
            exp_state = m_level ? ((m_run != 0) ? 2'd3 : 2'd2) : ((m_run != 0) ? 2'd1 : 2'd0);
            total++;
            if (oPulse !== m_pulse || oLevel !== m_level || oPressCnt !== m_cnt || oState !== exp_state) begin
                bad++;
                $display("FAIL cycle%0d: got pulse=%b level=%b cnt=%0d state=%0d, want pulse=%b level=%b cnt=%0d state=%0d",
                         cyc, oPulse, oLevel, oPressCnt, oState, m_pulse, m_level, m_cnt, exp_state);
            end
            if (oPulse === 1'b1) begin
                pulse_total++;
                pulse_q.push_back(32'(cyc));
                if (prev_pulse) b2b++;
            end
            prev_pulse = (oPulse === 1'b1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge CLK);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        RESET = 1'b1;
        iBtn  = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
    endtask

    // Waits for the next pulse and checks how many edges it came after edge0.
    task automatic expect_pulse(input string name, input int edge0, input int lat);
        bit ok;
        int e;
        ok = 1'b0;
        e  = -1;
        for (int i = 0; i < lat + 10; i++) begin
            tick();
            if (oPulse === 1'b1) begin
                ok = 1'b1;
                e  = cyc;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: no pulse seen, want one %0d edges after edge %0d", name, lat, edge0);
        end else begin
            check(name, e - edge0, lat);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        int p0;
        int b0;
        int pe;
        int len;

        // Test 1: reset state, then a clean press
        RESET = 1'b1;
        iBtn  = 1'b1;
        repeat (3) tick();
        check("rst_pulse", oPulse, 0);
        check("rst_level", oLevel, 0);
        check("rst_cnt", oPressCnt, 0);
        check("rst_state", oState, 0);
        RESET = 1'b0;
        iBtn  = 1'b0;
        e0 = cyc + 1;
        expect_pulse("t1_latency", e0, 6);
        check("t1_level", oLevel, 1);
        check("t1_cnt", oPressCnt, 1);
        tick();
        check("t1_pulse_one_cycle", oPulse, 0);
        repeat (5) tick();
        iBtn = 1'b1;
        repeat (12) tick();
        check("t1_released_level", oLevel, 0);
        check("t1_released_cnt", oPressCnt, 1);

        // Test 2: press bounce
        reset_dut();
        p0 = pulse_total;
        iBtn = 1'b0;
        repeat (3) tick();
        iBtn = 1'b1;
        tick();
        iBtn = 1'b0;
        e0 = cyc + 1;
        expect_pulse("t2_bounce_latency", e0, 6);
        check("t2_cnt", oPressCnt, 1);
        check("t2_pulses", pulse_total - p0, 1);

        // Test 3: release bounce while pressed
        repeat (3) tick();
        p0 = pulse_total;
        iBtn = 1'b1;
        repeat (2) tick();
        iBtn = 1'b0;
        repeat (2) tick();
        check("t3_level_during_bounce", oLevel, 1);
        iBtn = 1'b1;
        repeat (12) tick();
        check("t3_level_after", oLevel, 0);
        check("t3_cnt", oPressCnt, 1);
        check("t3_no_extra_pulse", pulse_total - p0, 0);

        // Test 4: 256 clean presses wrap the counter
        reset_dut();
        p0 = pulse_total;
        b0 = b2b;
        for (int i = 0; i < 256; i++) begin
            iBtn = 1'b0;
            repeat (9) tick();
            iBtn = 1'b1;
            repeat (9) tick();
        end
        check("t4_cnt_wrap", oPressCnt, 0);
        check("t4_pulses", pulse_total - p0, 256);
        check("t4_back_to_back", b2b - b0, 0);

        // Test 5: reset during PRESS_WAIT with the button held
        reset_dut();
        iBtn = 1'b0;
        repeat (4) tick();
        check("t5_in_press_wait", oState, 1);
        RESET = 1'b1;
        tick();
        check("t5_rst_pulse", oPulse, 0);
        check("t5_rst_level", oLevel, 0);
        check("t5_rst_cnt", oPressCnt, 0);
        check("t5_rst_state", oState, 0);
        RESET = 1'b0;
        e0 = cyc + 1;
        expect_pulse("t5_fresh_latency", e0, 6);
        check("t5_cnt", oPressCnt, 1);
        iBtn = 1'b1;
        repeat (12) tick();

        // Test 6: long hold (auto-repeat or single pulse)
        reset_dut();
        iBtn = 1'b0;
        e0 = cyc + 1;
        expect_pulse("t6_first", e0, 6);
        pe = cyc;
        pulse_q.delete();
        exp_q.delete();
        if (AUTOREP) begin
            for (int k = 0; k < 5; k++) exp_q.push_back(32'(pe + RS + k * RP));
        end
        while (cyc < pe + 54) tick();
        iBtn = 1'b1;
        repeat (30) tick();
        check("t6_repeat_count", pulse_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < pulse_q.size(); k++) begin
            check($sformatf("t6_repeat%0d_offset", k), int'(pulse_q[k]) - pe, int'(exp_q[k]) - pe);
        end
        check("t6_level", oLevel, 0);
        check("t6_cnt", oPressCnt, AUTOREP ? 6 : 1);

        // Random waveform with occasional resets, checked every cycle
        reset_dut();
        for (int r = 0; r < 400; r++) begin
            iBtn = 1'($urandom_range(0, 1));
            len  = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                RESET = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        RESET = 1'b0;
        iBtn  = 1'b1;
        repeat (20) tick();
        check("final_level", oLevel, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
